// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the integer pipeline: datapath width, register index
// width, the 5-bit ALU operation encodings and the ID/EX occupancy states.
// No ports; imported by the ID/EX stage, its interface and its sub-modules.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    // Bit 4 set marks the compare/branch group; the low bits pick the condition
    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b01000,
        ALU_XOR  = 5'b00100,
        ALU_OR   = 5'b00110,
        ALU_AND  = 5'b00111,
        ALU_SLL  = 5'b00001,
        ALU_SRL  = 5'b00101,
        ALU_SRA  = 5'b01101,
        ALU_SLT  = 5'b00010,
        ALU_SLTU = 5'b00011,
        ALU_BEQ  = 5'b10000,
        ALU_BNE  = 5'b10001,
        ALU_BLT  = 5'b10100,
        ALU_BGE  = 5'b10101,
        ALU_BLTU = 5'b10110,
        ALU_BGEU = 5'b10111
    } alu_op_e;

    // EMPTY: nothing held for the ALU stage. FULL: out_valid is asserted.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the decode-side offer (in_*) and the ALU-side result (out_*, alu_*)
// of the ID/EX pipeline register.
//   master : the surrounding pipeline (drives in_*, out_ready)
//   slave  : the ID/EX stage (drives in_ready and all registered outputs)
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int XLEN = riscv_pkg::XLEN
) ();
    import riscv_pkg::*;

    // Decode side
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_rs1_data;
    logic [XLEN-1:0]   in_rs2_data;
    logic [XLEN-1:0]   in_imm;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic [REG_W-1:0]  in_rd;
    logic [4:0]        in_alu_control;
    logic              in_use_pc;
    logic              in_use_imm;
    logic              in_reg_write;
    logic              in_mem_read;

    // ALU side
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [XLEN-1:0]   store_data;
    logic [XLEN-1:0]   out_pc;
    logic [4:0]        alu_control;
    logic [REG_W-1:0]  out_rd;
    logic              out_reg_write;
    logic              out_mem_read;

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1, in_rs2, in_rd, in_alu_control,
               in_use_pc, in_use_imm, in_reg_write, in_mem_read, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, store_data, out_pc,
               alu_control, out_rd, out_reg_write, out_mem_read
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1, in_rs2, in_rd, in_alu_control,
               in_use_pc, in_use_imm, in_reg_write, in_mem_read, out_ready,
        output in_ready, out_valid, alu_a, alu_b, store_data, out_pc,
               alu_control, out_rd, out_reg_write, out_mem_read
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Selects the freshest value of one source register.
//   rs_i / reg_data_i         : source index and register-file read
//   exmem_we/rd/data          : result sitting in EX/MEM (youngest, wins)
//   memwb_we/rd/data          : result sitting in MEM/WB
//   data_o                    : forwarded operand
// x0 is hard-wired zero in the register file, so it is never forwarded.
// ---------------------------------------------------------------------------
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic [XLEN-1:0]  reg_data_i,
    input  logic             exmem_we_i,
    input  logic [REG_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]  exmem_data_i,
    input  logic             memwb_we_i,
    input  logic [REG_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]  memwb_data_i,
    output logic [XLEN-1:0]  data_o
);

    logic exmemHit;
    logic memwbHit;

    assign exmemHit = exmem_we_i & (exmem_rd_i != '0) & (exmem_rd_i == rs_i);
    assign memwbHit = memwb_we_i & (memwb_rd_i != '0) & (memwb_rd_i == rs_i);

    always_comb begin
        data_o = reg_data_i;
        if (exmemHit) begin
            data_o = exmem_data_i;
        end else if (memwbHit) begin
            data_o = memwb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding, load-use interlock,
// backpressure and branch flush.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : decode offer in, registered ALU operands out
//   flush             : kill the held instruction (branch redirect)
//   fwd_exmem_*       : EX/MEM writeback candidate for forwarding
//   fwd_memwb_*       : MEM/WB writeback candidate for forwarding
// Operands are resolved once, at capture; a held entry never re-forwards.
// ---------------------------------------------------------------------------
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_stage_if.slave     bus,
    input  logic             flush,
    input  logic             fwd_exmem_we,
    input  logic             fwd_memwb_we,
    input  logic [REG_W-1:0] fwd_exmem_rd,
    input  logic [REG_W-1:0] fwd_memwb_rd,
    input  logic [XLEN-1:0]  fwd_exmem_data,
    input  logic [XLEN-1:0]  fwd_memwb_data
);

    stage_state_e     state_q, state_d;
    logic             loadUse;
    logic             inReady;
    logic             capture;
    logic [XLEN-1:0]  rs1Fwd, rs2Fwd;

    logic [XLEN-1:0]  aluA_q, aluB_q, storeData_q, outPc_q;
    logic [4:0]       aluControl_q;
    logic [REG_W-1:0] outRd_q;
    logic             outRegWrite_q, outMemRead_q;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_i         (bus.in_rs1),
        .reg_data_i   (bus.in_rs1_data),
        .exmem_we_i   (fwd_exmem_we),
        .exmem_rd_i   (fwd_exmem_rd),
        .exmem_data_i (fwd_exmem_data),
        .memwb_we_i   (fwd_memwb_we),
        .memwb_rd_i   (fwd_memwb_rd),
        .memwb_data_i (fwd_memwb_data),
        .data_o       (rs1Fwd)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_i         (bus.in_rs2),
        .reg_data_i   (bus.in_rs2_data),
        .exmem_we_i   (fwd_exmem_we),
        .exmem_rd_i   (fwd_exmem_rd),
        .exmem_data_i (fwd_exmem_data),
        .memwb_we_i   (fwd_memwb_we),
        .memwb_rd_i   (fwd_memwb_rd),
        .memwb_data_i (fwd_memwb_data),
        .data_o       (rs2Fwd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A held load whose rd feeds the offered instruction cannot be forwarded
    // yet (its data is not back from memory), so the offer is refused while
    // the load drains; that leaves exactly one bubble behind it.
    always_comb begin
        loadUse = (state_q == ST_FULL) & outMemRead_q & (outRd_q != '0) &
                  bus.in_valid &
                  ((outRd_q == bus.in_rs1) | (outRd_q == bus.in_rs2));
        inReady = ((state_q == ST_EMPTY) | bus.out_ready) & ~loadUse & ~flush;
        capture = bus.in_valid & inReady;

        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (capture) state_d = ST_FULL;
            ST_FULL: begin
                if (capture) begin
                    state_d = ST_FULL;
                end else if (bus.out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aluA_q        <= '0;
            aluB_q        <= '0;
            storeData_q   <= '0;
            outPc_q       <= '0;
            aluControl_q  <= '0;
            outRd_q       <= '0;
            outRegWrite_q <= 1'b0;
            outMemRead_q  <= 1'b0;
        end else if (capture) begin
            aluA_q        <= bus.in_use_pc  ? bus.in_pc  : rs1Fwd;
            aluB_q        <= bus.in_use_imm ? bus.in_imm : rs2Fwd;
            storeData_q   <= rs2Fwd;
            outPc_q       <= bus.in_pc;
            aluControl_q  <= bus.in_alu_control;
            outRd_q       <= bus.in_rd;
            outRegWrite_q <= bus.in_reg_write;
            outMemRead_q  <= bus.in_mem_read;
        end
    end

    assign bus.in_ready      = inReady;
    assign bus.out_valid     = (state_q == ST_FULL);
    assign bus.alu_a         = aluA_q;
    assign bus.alu_b         = aluB_q;
    assign bus.store_data    = storeData_q;
    assign bus.out_pc        = outPc_q;
    assign bus.alu_control   = aluControl_q;
    assign bus.out_rd        = outRd_q;
    assign bus.out_reg_write = outRegWrite_q;
    assign bus.out_mem_read  = outMemRead_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed self-checking bench for id_ex_stage. Inputs change 1 ns after the
// rising edge; registered outputs are observed there too, and in_ready is
// observed 1 ns after the inputs settle.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             fwd_exmem_we, fwd_memwb_we;
    logic [4:0]       fwd_exmem_rd, fwd_memwb_rd;
    logic [63:0]      fwd_exmem_data, fwd_memwb_data;

    int total = 0;
    int bad   = 0;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .flush          (flush),
        .fwd_exmem_we   (fwd_exmem_we),
        .fwd_memwb_we   (fwd_memwb_we),
        .fwd_exmem_rd   (fwd_exmem_rd),
        .fwd_memwb_rd   (fwd_memwb_rd),
        .fwd_exmem_data (fwd_exmem_data),
        .fwd_memwb_data (fwd_memwb_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setDefaults();
        bus.in_valid       = 1'b0;
        bus.in_pc          = '0;
        bus.in_rs1_data    = '0;
        bus.in_rs2_data    = '0;
        bus.in_imm         = '0;
        bus.in_rs1         = '0;
        bus.in_rs2         = '0;
        bus.in_rd          = '0;
        bus.in_alu_control = '0;
        bus.in_use_pc      = 1'b0;
        bus.in_use_imm     = 1'b0;
        bus.in_reg_write   = 1'b0;
        bus.in_mem_read    = 1'b0;
        bus.out_ready      = 1'b1;
        flush              = 1'b0;
        fwd_exmem_we       = 1'b0;
        fwd_memwb_we       = 1'b0;
        fwd_exmem_rd       = '0;
        fwd_memwb_rd       = '0;
        fwd_exmem_data     = '0;
        fwd_memwb_data     = '0;
    endtask

    task automatic test_reset();
        setDefaults();
        rst = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_rs1_data = 64'hDEAD;
        bus.in_pc       = 64'h80;
        bus.in_rd       = 5'd9;
        tick();
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.alu_a !== 64'h0) begin bad++; $display("[TB] FAIL reset_alu_a got=%h want=0", bus.alu_a); end
        total++; if (bus.out_pc !== 64'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h want=0", bus.out_pc); end
        total++; if (bus.out_rd !== 5'd0) begin bad++; $display("[TB] FAIL reset_rd got=%0d want=0", bus.out_rd); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_plain_add();
        setDefaults();
        bus.in_valid       = 1'b1;
        bus.in_rs1         = 5'd1;
        bus.in_rs2         = 5'd2;
        bus.in_rd          = 5'd3;
        bus.in_rs1_data    = 64'd5;
        bus.in_rs2_data    = 64'd3;
        bus.in_pc          = 64'h40;
        bus.in_reg_write   = 1'b1;
        bus.in_alu_control = ALU_ADD;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL add_ready got=%b want=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL add_valid got=%b want=1", bus.out_valid); end
        total++; if (bus.alu_a !== 64'd5) begin bad++; $display("[TB] FAIL add_alu_a got=%h want=5", bus.alu_a); end
        total++; if (bus.alu_b !== 64'd3) begin bad++; $display("[TB] FAIL add_alu_b got=%h want=3", bus.alu_b); end
        total++; if (bus.store_data !== 64'd3) begin bad++; $display("[TB] FAIL add_store got=%h want=3", bus.store_data); end
        total++; if (bus.alu_control !== 5'b00000) begin bad++; $display("[TB] FAIL add_ctrl got=%b want=00000", bus.alu_control); end
        total++; if (bus.out_rd !== 5'd3 || bus.out_reg_write !== 1'b1 || bus.out_pc !== 64'h40)
            begin bad++; $display("[TB] FAIL add_ctl rd=%0d we=%b pc=%h want rd=3 we=1 pc=40", bus.out_rd, bus.out_reg_write, bus.out_pc); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_drain got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_double_forward();
        setDefaults();
        bus.in_valid    = 1'b1;
        bus.in_rs1      = 5'd7;
        bus.in_rs2      = 5'd9;
        bus.in_rs1_data = 64'h99;
        bus.in_rs2_data = 64'h55;
        fwd_exmem_we = 1'b1; fwd_exmem_rd = 5'd7; fwd_exmem_data = 64'h11;
        fwd_memwb_we = 1'b1; fwd_memwb_rd = 5'd7; fwd_memwb_data = 64'h22;
        tick();
        total++; if (bus.alu_a !== 64'h11) begin bad++; $display("[TB] FAIL fwd_prio got=%h want=11", bus.alu_a); end
        total++; if (bus.alu_b !== 64'h55) begin bad++; $display("[TB] FAIL fwd_nohit got=%h want=55", bus.alu_b); end
        // x0 must never be forwarded
        bus.in_rs1 = 5'd0; bus.in_rs1_data = 64'h77;
        fwd_exmem_rd = 5'd0; fwd_memwb_rd = 5'd0;
        tick();
        total++; if (bus.alu_a !== 64'h77) begin bad++; $display("[TB] FAIL fwd_x0 got=%h want=77", bus.alu_a); end
        // Only MEM/WB matches; it also feeds rs2
        bus.in_rs1 = 5'd4; bus.in_rs2 = 5'd4; bus.in_rs1_data = 64'h99; bus.in_rs2_data = 64'h98;
        fwd_exmem_rd = 5'd3; fwd_memwb_rd = 5'd4;
        tick();
        total++; if (bus.alu_a !== 64'h22) begin bad++; $display("[TB] FAIL fwd_memwb got=%h want=22", bus.alu_a); end
        total++; if (bus.store_data !== 64'h22) begin bad++; $display("[TB] FAIL fwd_rs2 got=%h want=22", bus.store_data); end
        // Write enables low: no forwarding even on index match
        fwd_exmem_rd = 5'd4; fwd_exmem_we = 1'b0; fwd_memwb_we = 1'b0;
        tick();
        total++; if (bus.alu_a !== 64'h99) begin bad++; $display("[TB] FAIL fwd_we_low got=%h want=99", bus.alu_a); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        setDefaults();
        bus.in_valid = 1'b1; bus.in_mem_read = 1'b1; bus.in_reg_write = 1'b1;
        bus.in_rd = 5'd5; bus.in_rs1 = 5'd1;
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_mem_read !== 1'b1 || bus.out_rd !== 5'd5)
            begin bad++; $display("[TB] FAIL lu_load v=%b mr=%b rd=%0d want 1 1 5", bus.out_valid, bus.out_mem_read, bus.out_rd); end
        bus.in_mem_read = 1'b0; bus.in_rd = 5'd8; bus.in_rs1 = 5'd6;
        bus.in_rs2 = 5'd5; bus.in_rs2_data = 64'hAB;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL lu_stall got=%b want=0", bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lu_bubble got=%b want=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL lu_release got=%b want=1", bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd8 || bus.alu_b !== 64'hAB)
            begin bad++; $display("[TB] FAIL lu_capture v=%b rd=%0d b=%h want 1 8 ab", bus.out_valid, bus.out_rd, bus.alu_b); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        setDefaults();
        bus.in_valid = 1'b1; bus.in_rs1_data = 64'h111; bus.in_rd = 5'd10; bus.in_pc = 64'h200;
        tick();
        bus.out_ready = 1'b0;
        bus.in_rs1_data = 64'h222; bus.in_rd = 5'd11; bus.in_pc = 64'h204;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready[%0d] got=%b want=0", i, bus.in_ready); end
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.alu_a !== 64'h111 || bus.out_pc !== 64'h200 || bus.out_rd !== 5'd10)
                begin bad++; $display("[TB] FAIL bp_hold[%0d] v=%b a=%h pc=%h rd=%0d want 1 111 200 10", i, bus.out_valid, bus.alu_a, bus.out_pc, bus.out_rd); end
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_go got=%b want=1", bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.alu_a !== 64'h222 || bus.out_pc !== 64'h204)
            begin bad++; $display("[TB] FAIL bp_next v=%b a=%h pc=%h want 1 222 204", bus.out_valid, bus.alu_a, bus.out_pc); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        setDefaults();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_rs1_data = 64'h1000 + 64'(i);
            bus.in_rs2_data = 64'(i);
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.alu_a !== 64'h1000 + 64'(i))
                begin bad++; $display("[TB] FAIL b2b[%0d] v=%b a=%h want 1 %h", i, bus.out_valid, bus.alu_a, 64'h1000 + 64'(i)); end
        end
        bus.in_valid = 1'b0;
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        setDefaults();
        bus.in_valid = 1'b1; bus.in_rs1_data = 64'h33;
        tick();
        bus.in_rs1_data = 64'h44;
        flush = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready got=%b want=0", bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_kill got=%b want=0", bus.out_valid); end
        flush = 1'b0;
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.alu_a !== 64'h44)
            begin bad++; $display("[TB] FAIL flush_after v=%b a=%h want 1 44", bus.out_valid, bus.alu_a); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_stall();
        setDefaults();
        bus.in_valid = 1'b1; bus.in_rs1_data = 64'h5A; bus.in_rs2_data = 64'h6B; bus.in_imm = 64'h4;
        bus.in_pc = 64'h300; bus.in_rd = 5'd12; bus.in_reg_write = 1'b1; bus.in_mem_read = 1'b1;
        bus.in_alu_control = ALU_SRA; bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd2;
        tick();
        bus.out_ready = 1'b0;
        bus.in_mem_read = 1'b0;
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.alu_a !== 64'h5A)
            begin bad++; $display("[TB] FAIL rs_held v=%b a=%h want 1 5a", bus.out_valid, bus.alu_a); end
        rst = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.alu_a !== 64'h0 || bus.alu_b !== 64'h0 || bus.store_data !== 64'h0 ||
                     bus.out_pc !== 64'h0 || bus.out_rd !== 5'd0 || bus.alu_control !== 5'd0 ||
                     bus.out_reg_write !== 1'b0 || bus.out_mem_read !== 1'b0)
            begin bad++; $display("[TB] FAIL rs_clear v=%b a=%h b=%h s=%h pc=%h rd=%0d c=%b we=%b mr=%b want all 0",
                bus.out_valid, bus.alu_a, bus.alu_b, bus.store_data, bus.out_pc, bus.out_rd, bus.alu_control, bus.out_reg_write, bus.out_mem_read); end
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rs_ready got=%b want=1", bus.in_ready); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_imm_pc();
        setDefaults();
        bus.in_valid = 1'b1; bus.in_use_pc = 1'b1; bus.in_use_imm = 1'b1;
        bus.in_pc = 64'h1000; bus.in_imm = 64'h10;
        bus.in_rs1 = 5'd6; bus.in_rs1_data = 64'h7; bus.in_rs2 = 5'd6; bus.in_rs2_data = 64'h1;
        bus.in_alu_control = ALU_SUB;
        fwd_exmem_we = 1'b1; fwd_exmem_rd = 5'd6; fwd_exmem_data = 64'hBEEF;
        tick();
        total++; if (bus.alu_a !== 64'h1000) begin bad++; $display("[TB] FAIL sel_a got=%h want=1000", bus.alu_a); end
        total++; if (bus.alu_b !== 64'h10) begin bad++; $display("[TB] FAIL sel_b got=%h want=10", bus.alu_b); end
        total++; if (bus.store_data !== 64'hBEEF) begin bad++; $display("[TB] FAIL sel_store got=%h want=beef", bus.store_data); end
        total++; if (bus.alu_control !== 5'b01000) begin bad++; $display("[TB] FAIL sel_ctrl got=%b want=01000", bus.alu_control); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        setDefaults();
        test_reset();
        test_plain_add();
        test_double_forward();
        test_load_use();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_stall();
        test_imm_pc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
